d_flip_flop: RTL and testbench

- Single-clock, positive-edge D-type storage element with synchronous, active-low reset.
- Leaf primitive used wherever one registered bit, or a registered bus, is needed.
- Default configuration is one bit wide with a reset value of 0.
- Port declaration order is fixed for positional instantiation by existing users: q, clk, n_rst, din.

---
 rtl/d_flip_flop.sv | 22 ++
 tb/tb_d_flip_flop.sv | 110 +++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// Positive-edge D-type register of parameterisable width.
// Reset is synchronous and active-low; q comes straight from the storage flop.
module d_flip_flop #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = {WIDTH{1'b0}}
) (
  output logic [WIDTH-1:0] q,
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] din
);

  // Reset wins over data; n_rst is only seen at the rising edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      q <= RST_VAL;
    end else begin
      q <= din;
    end
  end

endmodule

// File: tb/tb_d_flip_flop.sv
// Directed checks of d_flip_flop: default 1-bit instance, a chained 1-bit
// stage, and an 8-bit instance with a non-zero reset value.
module tb_d_flip_flop;

  logic       clk;
  logic       n_rst;
  logic       din;
  logic       q1;
  logic       q1b;
  logic       n_rst8;
  logic [7:0] din8;
  logic [7:0] q8;
  logic       one;

  int unsigned n_vec;
  int unsigned n_err;

  d_flip_flop u_dff1 (
    .q     (q1),
    .clk   (clk),
    .n_rst (n_rst),
    .din   (din)
  );

  // Second stage fed by the first: must see the pre-edge value of q1.
  d_flip_flop u_dff1b (
    .q     (q1b),
    .clk   (clk),
    .n_rst (one),
    .din   (q1)
  );

  d_flip_flop #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dff8 (
    .q     (q8),
    .clk   (clk),
    .n_rst (n_rst8),
    .din   (din8)
  );

  // Period 20 ns, first rising edge at 10 ns.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_until(input time t);
    if (t > $time) #(t - $time);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    one    = 1'b1;
    n_rst  = 1'b1;
    din    = 1'b0;
    n_rst8 = 1'b1;
    din8   = 8'h00;

    wait_until(11);  check_val("first_edge_load", 8'(q1), 8'h00);
    wait_until(20);  n_rst = 1'b0;
    wait_until(21);  check_val("no_async_clear_20", 8'(q1), 8'h00);
    wait_until(31);  check_val("reset_at_30", 8'(q1), 8'h00);
    din = 1'b1;
    wait_until(51);  check_val("reset_prio_50", 8'(q1), 8'h00);
    n_rst = 1'b1;
    wait_until(60);  check_val("no_early_load_60", 8'(q1), 8'h00);
    wait_until(68);  din = 1'b0;
    wait_until(69);  din = 1'b1;
    wait_until(71);  check_val("release_load_70", 8'(q1), 8'h01);
    wait_until(80);  check_val("hold_80", 8'(q1), 8'h01);
    wait_until(88);  check_val("hold_88", 8'(q1), 8'h01);
    wait_until(89);  din = 1'b0;
    wait_until(91);  check_val("load_zero_90", 8'(q1), 8'h00);
    wait_until(100); check_val("hold_100", 8'(q1), 8'h00);

    // Reset falling while q is 1 must not clear it before the next edge.
    wait_until(101); din = 1'b1;
    wait_until(111); check_val("load_one_110", 8'(q1), 8'h01);
    check_val("chain_110", 8'(q1b), 8'h00);
    wait_until(115); n_rst = 1'b0;
    wait_until(125); check_val("no_async_clear_125", 8'(q1), 8'h01);
    wait_until(131); check_val("sync_reset_130", 8'(q1), 8'h00);
    check_val("chain_130", 8'(q1b), 8'h01);
    wait_until(135); n_rst = 1'b1;

    // 8-bit instance with RST_VAL = A5.
    wait_until(141); din8 = 8'h3C;
    wait_until(151); check_val("w8_load_150", q8, 8'h3C);
    wait_until(155); n_rst8 = 1'b0; din8 = 8'hFF;
    wait_until(165); check_val("w8_hold_165", q8, 8'h3C);
    wait_until(171); check_val("w8_reset_170", q8, 8'hA5);
    wait_until(175); n_rst8 = 1'b1;
    wait_until(191); check_val("w8_load_190", q8, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
